// File: rtl/frs_pkg.sv
// Shared definitions for the frame restore path: state encoding, frame geometry
// and helpers reused by both the restore and backup sides.
package frs_pkg;

   localparam int FRS_NUM_REGS = 16;
   localparam int FRS_REG_W    = 16;
   localparam int FRS_DEPTH    = 32;
   localparam int FRAME_W      = FRS_NUM_REGS * FRS_REG_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } frs_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Register i occupies frame[i*REG_W +: REG_W].
   function automatic logic [FRS_REG_W-1:0] frame_word(input logic [FRAME_W-1:0] frame,
                                                       input int i);
      return frame[i*FRS_REG_W +: FRS_REG_W];
   endfunction

endpackage

// File: rtl/frs_depth_ctr.sv
// Saturating up/down occupancy counter for the frame stack, with full/empty
// status and detection of pushes when full and pops when empty.
module frs_depth_ctr
   import frs_pkg::*;
#(
   parameter  int DEPTH = FRS_DEPTH,
   localparam int W     = clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] depth_o,
   output logic         full_o,
   output logic         empty_o,
   output logic         ovf_o,
   output logic         udf_o
);

   logic [W-1:0] depth_q;
   logic [W-1:0] depth_d;

   assign full_o  = (depth_q == W'(DEPTH));
   assign empty_o = (depth_q == '0);
   assign ovf_o   = inc_i & full_o;
   assign udf_o   = dec_i & empty_o;
   assign depth_o = depth_q;

   always_comb begin
      depth_d = depth_q;
      if (inc_i && !dec_i && !full_o)
         depth_d = depth_q + 1'b1;
      else if (dec_i && !inc_i && !empty_o)
         depth_d = depth_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) depth_q <= '0;
      else       depth_q <= depth_d;
   end

endmodule

// File: rtl/frame_restore_seq.sv
// Return-side sequencer: on ret_req pops one frame from the backup stack, then
// writes it back into the register file one register per cycle.
module frame_restore_seq
   import frs_pkg::*;
#(
   parameter  int                  NUM_REGS      = FRS_NUM_REGS,
   parameter  int                  REG_W         = FRS_REG_W,
   parameter  int                  DEPTH         = FRS_DEPTH,
   parameter  logic [NUM_REGS-1:0] PRESERVE_MASK = 16'h0001,
   localparam int                  IDX_W         = clog2(NUM_REGS),
   localparam int                  DEPTH_W       = clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      call_req,
   input  logic                      ret_req,
   input  logic [NUM_REGS*REG_W-1:0] frame_in,
   output logic                      fbs_restore,
   output logic                      rf_we,
   output logic [IDX_W-1:0]          rf_waddr,
   output logic [REG_W-1:0]          rf_wdata,
   output logic                      busy,
   output logic                      done,
   output logic [DEPTH_W-1:0]        depth,
   output logic                      err_ovf,
   output logic                      err_udf,
   output logic                      err_proto
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   frs_state_e                state_q;
   logic [IDX_W-1:0]          idx_q;
   logic [IDX_W-1:0]          idx_d;
   logic [NUM_REGS*REG_W-1:0] shadow_q;
   logic                      fbs_q, busy_q, done_q, rf_we_q;
   logic [IDX_W-1:0]          rf_waddr_q;
   logic [REG_W-1:0]          rf_wdata_q;
   logic                      err_ovf_q, err_udf_q, err_proto_q;

   logic call_ok, ret_ok, proto_req, start, udf_req, pop;
   logic ctr_empty, ctr_full, ctr_ovf, ctr_udf;

   // Requests while busy, or both at once, are rejected and only flagged.
   assign proto_req = (busy_q & (call_req | ret_req)) | (call_req & ret_req);
   assign call_ok   = call_req & ~ret_req & ~busy_q;
   assign ret_ok    = ret_req & ~call_req & ~busy_q;
   assign start     = ret_ok & ~ctr_empty;
   assign udf_req   = ret_ok & ctr_empty;
   assign pop       = (state_q == POP);
   assign idx_d     = idx_q + 1'b1;

   frs_depth_ctr #(.DEPTH(DEPTH)) u_depth (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (call_ok),
      .dec_i   (pop),
      .depth_o (depth),
      .full_o  (ctr_full),
      .empty_o (ctr_empty),
      .ovf_o   (ctr_ovf),
      .udf_o   (ctr_udf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         shadow_q    <= '0;
         fbs_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         err_ovf_q   <= 1'b0;
         err_udf_q   <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         fbs_q  <= 1'b0;
         done_q <= 1'b0;
         if (ctr_ovf)            err_ovf_q   <= 1'b1;
         if (udf_req || ctr_udf) err_udf_q   <= 1'b1;
         if (proto_req)          err_proto_q <= 1'b1;
         unique case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               if (start) begin
                  state_q <= POP;
                  fbs_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            POP: begin
               // Register 0 goes out straight from frame_in; the shadow is
               // only readable from the next cycle on.
               shadow_q   <= frame_in;
               idx_q      <= '0;
               rf_we_q    <= ~PRESERVE_MASK[0];
               rf_waddr_q <= '0;
               rf_wdata_q <= frame_word(frame_in, 0);
               state_q    <= WRITE;
            end
            WRITE: begin
               if (idx_q == LAST_IDX) begin
                  rf_we_q <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q      <= idx_d;
                  rf_we_q    <= ~PRESERVE_MASK[idx_d];
                  rf_waddr_q <= idx_d;
                  rf_wdata_q <= frame_word(shadow_q, int'(idx_d));
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fbs_restore = fbs_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign rf_we       = rf_we_q;
   assign rf_waddr    = rf_waddr_q;
   assign rf_wdata    = rf_wdata_q;
   assign err_ovf     = err_ovf_q;
   assign err_udf     = err_udf_q;
   assign err_proto   = err_proto_q;

endmodule

// File: tb/tb_frame_restore_seq.sv
// Bench for frame_restore_seq: directed scenarios plus random traffic, checked
// against a timeline model (offset from the accepted ret_req) of the restore.
module tb_frame_restore_seq;

   localparam logic [15:0] MASK = 16'h0001;

   logic         clk = 1'b0;
   logic         reset, call_req, ret_req;
   logic [255:0] frame_in;
   logic         fbs_restore, rf_we, busy, done;
   logic [3:0]   rf_waddr;
   logic [15:0]  rf_wdata;
   logic [5:0]   depth;
   logic         err_ovf, err_udf, err_proto;

   frame_restore_seq dut (
      .clk         (clk),
      .reset       (reset),
      .call_req    (call_req),
      .ret_req     (ret_req),
      .frame_in    (frame_in),
      .fbs_restore (fbs_restore),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy),
      .done        (done),
      .depth       (depth),
      .err_ovf     (err_ovf),
      .err_udf     (err_udf),
      .err_proto   (err_proto)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: cycle count, cycle of last accepted ret_req, captured frame.
   int           cyc = 0;
   int           rstart = -1000;
   int           m_depth = 0;
   logic         m_ovf = 0, m_udf = 0, m_proto = 0, m_fresh = 1;
   logic [255:0] m_cap = '0;
   logic [255:0] frame_v = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic c_in, input logic r_in, input logic rst_in);
      int  d;
      logic bsy;
      @(negedge clk);
      d   = cyc - rstart;
      bsy = (d >= 1 && d <= 17);
      check_val("fbs_restore", fbs_restore, d == 1);
      check_val("busy", busy, bsy);
      check_val("done", done, d == 18);
      check_val("rf_we", rf_we, (d >= 2 && d <= 17) ? !MASK[d-2] : 1'b0);
      if (d >= 2 && d <= 17) begin
         check_val("rf_waddr", rf_waddr, d - 2);
         check_val("rf_wdata", rf_wdata, m_cap[(d-2)*16 +: 16]);
      end else if (m_fresh) begin
         check_val("rf_waddr_rst", rf_waddr, 0);
         check_val("rf_wdata_rst", rf_wdata, 0);
      end
      check_val("depth", depth, m_depth);
      check_val("err_ovf", err_ovf, m_ovf);
      check_val("err_udf", err_udf, m_udf);
      check_val("err_proto", err_proto, m_proto);

      call_req = c_in;
      ret_req  = r_in;
      reset    = rst_in;
      frame_in = frame_v;

      if (rst_in) begin
         rstart = -1000; m_depth = 0; m_ovf = 0; m_udf = 0; m_proto = 0; m_fresh = 1;
      end else begin
         if (d == 1) begin
            m_depth--;
            m_cap   = frame_v;
            m_fresh = 0;
         end
         if (bsy && (c_in || r_in)) m_proto = 1;
         else if (c_in && r_in)     m_proto = 1;
         else if (c_in) begin
            if (m_depth == 32) m_ovf = 1;
            else               m_depth++;
         end else if (r_in) begin
            if (m_depth == 0) m_udf = 1;
            else              rstart = cyc;
         end
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; call_req = 1'b0; ret_req = 1'b0; frame_in = '0;
      @(posedge clk);
      @(posedge clk);
      step(1'b0, 1'b0, 1'b1);
      idle(2);

      // Single call then return with a recognisable frame.
      for (int i = 0; i < 16; i++) frame_v[i*16 +: 16] = 16'hA000 + 16'(i);
      step(1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0);
      idle(22);

      // Return on an empty stack.
      step(1'b0, 1'b1, 1'b0);
      idle(3);

      // Fill to capacity, then one more call.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 33; i++) step(1'b1, 1'b0, 1'b0);
      idle(2);

      // Return request arriving mid-write is rejected.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      frame_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(1'b0, 1'b1, 1'b0);
      idle(5);
      step(1'b0, 1'b1, 1'b0);
      idle(16);

      // Simultaneous call and return at depth 3.
      step(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      idle(3);

      // Back-to-back returns: second one accepted in the done cycle.
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      idle(17);
      frame_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      step(1'b0, 1'b1, 1'b0);
      idle(20);

      // Reset in the middle of a restore.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      idle(7);
      step(1'b0, 1'b0, 1'b1);
      idle(20);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic c, r, rs;
         frame_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         c  = ($urandom_range(0, 3) == 0);
         r  = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 499) == 0);
         step(c, r, rs);
      end
      idle(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frame_restore_seq.md
Name: frame_restore_seq

Overview:
- Return-side sequencer for the F-register backup system.
- On a procedure return it pops one 256-bit frame from the frame backup stack by pulsing that block's restore input. It latches the frame and writes it back into the register file one register per cycle.
- It also tracks stack occupancy from observed backups and pops, and flags overflow, underflow and protocol misuse to the control unit.

Parameters:
- NUM_REGS, 16, registers per frame (restore index width = clog2(NUM_REGS)).
- REG_W, 16, bits per register; frame width = NUM_REGS*REG_W = 256.
- DEPTH, 32, frame-cache capacity in frames; depth counter width = clog2(DEPTH+1).
- PRESERVE_MASK, 16'h0001, bit i set: register i is not overwritten on restore (zero/return-value register).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- call_req  in  1  one-cycle pulse, same cycle the backup system's backup is asserted; counted only.
- ret_req  in  1  one-cycle pulse requesting a frame restore.
- frame_in  in  256  frame-stack read data; valid in the cycle fbs_restore is high.
- fbs_restore  out  1  one-cycle pop strobe to the backup system.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  4  register-file write index.
- rf_wdata  out  16  register-file write data.
- busy  out  1  restore in progress; control stalls the pipeline while high.
- done  out  1  one-cycle pulse, restore complete.
- depth  out  6  frames currently on the stack.
- err_ovf  out  1  sticky: call_req with depth==DEPTH.
- err_udf  out  1  sticky: ret_req with depth==0.
- err_proto  out  1  sticky: illegal request timing.

Behaviour:
- Reset values:
  - fbs_restore, rf_we, busy, done = 0.
  - rf_waddr = 0, rf_wdata = 0, depth = 0.
  - All err flags = 0; shadow frame = 0; state = IDLE.
- Reset mid-restore aborts the sequence. From the next cycle rf_we=0 and no further writes occur. System reset must also clear the backup system pointer.
- Frame packing: register i = frame[i*REG_W +: REG_W].
- FSM states: IDLE, POP, WRITE, DONE.
- IDLE:
  - ret_req with depth>0 -> POP.
  - ret_req with depth==0 -> set err_udf, stay IDLE, no strobe.
- POP (1 cycle):
  - fbs_restore=1, busy=1.
  - Shadow <= frame_in at the clock edge ending the cycle.
  - depth <= depth-1; idx <= 0.
  - -> WRITE.
- WRITE (NUM_REGS cycles, idx 0..NUM_REGS-1):
  - busy=1, rf_waddr=idx, rf_wdata=shadow[idx].
  - rf_we = ~PRESERVE_MASK[idx]. Masked slots still take one cycle, so latency is fixed.
  - -> DONE after idx==NUM_REGS-1.
- DONE (1 cycle): done=1, busy=0 -> IDLE.
- Latency: with ret_req sampled at edge k:
  - POP runs in cycle k+1.
  - Register i is written in cycle k+2+i.
  - done is high in cycle k+18.
  - busy is high in cycles k+1..k+17.
  - A new ret_req is accepted in the DONE cycle.
- Depth accounting:
  - call_req in IDLE/DONE with depth<DEPTH -> depth+1.
  - call_req with depth==DEPTH -> err_ovf, no increment.
- Protocol errors (set err_proto):
  - call_req or ret_req while busy: the request is ignored and not counted.
  - call_req and ret_req in the same cycle: neither acted upon.
- Sticky flags clear only on reset.
- Outputs are registered; frame_in is the only combinational-path input used.

Decomposition:
- Shared package frs_pkg: state encoding (IDLE=2'd0, POP=2'd1, WRITE=2'd2, DONE=2'd3), FRAME_W, the clog2 helper, and a frame_word(frame, i) slice function for reuse by the backup side.
- One natural sub-module, frs_depth_ctr: saturating up/down occupancy counter with full/empty outputs and overflow/underflow detection.
- The FSM and shadow register stay in the top.

Test Plan:
- Reset, then call_req x1, frame_in word i = 16'hA000+i, then ret_req:
  - fbs_restore high exactly 1 cycle.
  - Writes at cycles k+3..k+17 to regs 1..15 with data A001..A00F; reg 0 not written.
  - done at k+18; depth 1->0.
- ret_req at depth 0 -> no fbs_restore, busy stays 0, err_udf=1, depth stays 0.
- 32 call_req pulses, then a 33rd -> depth=32, err_ovf=1, depth not 33.
- ret_req during WRITE (cycle k+6) -> ignored, err_proto=1, only one pop, depth decremented once.
- Simultaneous call_req and ret_req in IDLE with depth=3 -> depth stays 3, no pop, err_proto=1.
- reset asserted at cycle k+8 -> rf_we=0 from k+9, busy=0, depth=0, no done pulse.
